// File: rtl/uart_tx_arbiter_if.sv
// Bundle of request, grant and transmitter-handshake signals between the
// requesters/transmitter side (master) and the uart_tx_arbiter (slave).
interface uart_tx_arbiter_if;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic [3:0]  o_ack;
  logic [3:0]  o_done;
  logic        o_timeout;
  logic        o_tx_data_avail;
  logic [7:0]  o_tx_data_byte;
  logic        i_tx_active;
  logic        i_tx_done;
  logic        o_busy;
  logic [1:0]  o_owner;

  modport slave (
    input  i_req, i_data, i_tx_active, i_tx_done,
    output o_ack, o_done, o_timeout, o_tx_data_avail, o_tx_data_byte,
           o_busy, o_owner
  );

  modport master (
    output i_req, i_data, i_tx_active, i_tx_done,
    input  o_ack, o_done, o_timeout, o_tx_data_avail, o_tx_data_byte,
           o_busy, o_owner
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Four-requester arbiter in front of a single UART transmitter.
// Grants one byte at a time in round-robin order, launches it, then waits
// for the transmitter to report active/done, abandoning the byte if the
// transmitter never starts within START_TIMEOUT cycles.
// Optional macro UART_ARB_PRIO0_EN: requester 0 always wins when requesting;
// round-robin then only arbitrates among requesters 1..3.
module uart_tx_arbiter #(
  parameter int START_TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACTIVE = 2'd1,
    WAIT_DONE   = 2'd2
  } state_t;

  localparam logic [7:0] TimeoutLast = 8'(START_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] ack_q, ack_d;
  logic [3:0] done_q, done_d;
  logic       timeout_q, timeout_d;
  logic       avail_q, avail_d;
  logic [7:0] txByte_q, txByte_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] lastOwner_q, lastOwner_d;
  logic [7:0] count_q, count_d;
  logic [1:0] pick;

  // Lowest ascending offset from the last owner wins; iterating downwards
  // lets the nearest candidate overwrite farther ones.
  function automatic logic [1:0] rrPick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    win = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

  // Choose the requester that would be granted at this edge.
  always_comb begin
`ifdef UART_ARB_PRIO0_EN
    if (bus.i_req[0]) pick = 2'd0;
    else              pick = rrPick({bus.i_req[3:1], 1'b0}, lastOwner_q);
`else
    pick = rrPick(bus.i_req, lastOwner_q);
`endif
  end

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    ack_d       = 4'b0000;
    done_d      = 4'b0000;
    timeout_d   = 1'b0;
    avail_d     = 1'b0;
    txByte_d    = txByte_q;
    owner_d     = owner_q;
    lastOwner_d = lastOwner_q;
    count_d     = count_q;
    case (state_q)
      IDLE: begin
        if ((|bus.i_req) && !bus.i_tx_active) begin
          ack_d    = 4'b0001 << pick;
          avail_d  = 1'b1;
          txByte_d = bus.i_data[{pick, 3'b000} +: 8];
          owner_d  = pick;
          count_d  = 8'd0;
          state_d  = WAIT_ACTIVE;
        end
      end
      WAIT_ACTIVE: begin
        if (bus.i_tx_done) begin
          done_d      = 4'b0001 << owner_q;
          lastOwner_d = owner_q;
          state_d     = IDLE;
        end else if (bus.i_tx_active) begin
          state_d = WAIT_DONE;
        end else begin
          count_d = count_q + 8'd1;
          if (count_q + 8'd1 == TimeoutLast) begin
            timeout_d   = 1'b1;
            lastOwner_d = owner_q;
            state_d     = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (bus.i_tx_done) begin
          done_d      = 4'b0001 << owner_q;
          lastOwner_d = owner_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any byte in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ack_q       <= 4'b0000;
      done_q      <= 4'b0000;
      timeout_q   <= 1'b0;
      avail_q     <= 1'b0;
      txByte_q    <= 8'h00;
      owner_q     <= 2'd0;
      lastOwner_q <= 2'd3;
      count_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      avail_q     <= avail_d;
      txByte_q    <= txByte_d;
      owner_q     <= owner_d;
      lastOwner_q <= lastOwner_d;
      count_q     <= count_d;
    end
  end

  assign bus.o_ack           = ack_q;
  assign bus.o_done          = done_q;
  assign bus.o_timeout       = timeout_q;
  assign bus.o_tx_data_avail = avail_q;
  assign bus.o_tx_data_byte  = txByte_q;
  assign bus.o_owner         = owner_q;
  assign bus.o_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios with literal
// expectations plus a transaction-level reference model compared every cycle.
module tb_uart_tx_arbiter;

  localparam int TO = 16;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.START_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a scenario never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic act, input logic dn);
    bus.i_req       = req;
    bus.i_tx_active = act;
    bus.i_tx_done   = dn;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one launched byte at a time; it either completes on a
  // done pulse, or is abandoned after TO-1 cycles with the transmitter idle.
  logic [3:0] mAck, mDone;
  logic       mTimeout, mAvail;
  logic [7:0] mByte;
  int         mOwner, mLast, mAge, mWinner;
  bit         mBusy, mSeenActive;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mAck = 0; mDone = 0; mTimeout = 0; mAvail = 0; mByte = 0;
      mOwner = 0; mLast = 3; mAge = 0; mBusy = 0; mSeenActive = 0;
    end else begin
      mAck = 0; mDone = 0; mTimeout = 0; mAvail = 0;
      if (!mBusy) begin
        if (bus.i_req != 4'b0000 && !bus.i_tx_active) begin
          mWinner = -1;
`ifdef UART_ARB_PRIO0_EN
          if (bus.i_req[0]) mWinner = 0;
`endif
          for (int n = 1; n <= 4; n++)
            if (mWinner < 0 && bus.i_req[(mLast + n) % 4]) mWinner = (mLast + n) % 4;
          mAck[mWinner] = 1'b1;
          mAvail        = 1'b1;
          mByte         = bus.i_data[mWinner*8 +: 8];
          mOwner        = mWinner;
          mBusy         = 1;
          mSeenActive   = 0;
          mAge          = 0;
        end
      end else if (bus.i_tx_done) begin
        mDone[mOwner] = 1'b1;
        mLast         = mOwner;
        mBusy         = 0;
      end else if (!mSeenActive) begin
        if (bus.i_tx_active) mSeenActive = 1;
        else begin
          mAge++;
          if (mAge == TO - 1) begin
            mTimeout = 1'b1;
            mLast    = mOwner;
            mBusy    = 0;
          end
        end
      end
    end
  end

  // Compare every output against the model mid-cycle while out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("model.ack",     32'(bus.o_ack),           32'(mAck));
      checkOutput("model.done",    32'(bus.o_done),          32'(mDone));
      checkOutput("model.timeout", 32'(bus.o_timeout),       32'(mTimeout));
      checkOutput("model.avail",   32'(bus.o_tx_data_avail), 32'(mAvail));
      checkOutput("model.byte",    32'(bus.o_tx_data_byte),  32'(mByte));
      checkOutput("model.owner",   32'(bus.o_owner),         32'(mOwner));
      checkOutput("model.busy",    32'(bus.o_busy),          32'(mBusy));
    end
  end

  // Directed scenarios.
  initial begin
    int n;
    int sawDone;
    logic [3:0] expAck;
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    bus.i_data = 32'h44_22_11_55;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    checkOutput("reset.ack",   32'(bus.o_ack),          32'h0);
    checkOutput("reset.byte",  32'(bus.o_tx_data_byte), 32'h0);
    checkOutput("reset.owner", 32'(bus.o_owner),        32'h0);
    checkOutput("reset.busy",  32'(bus.o_busy),         32'h0);

    // Requesters 1 and 2: 1 first, then 2 after completion.
    applyStimulus(4'b0110, 1'b0, 1'b0);
    stepCycle();
    checkOutput("rr.firstAck",   32'(bus.o_ack),           32'h2);
    checkOutput("rr.firstByte",  32'(bus.o_tx_data_byte),  32'h11);
    checkOutput("rr.firstAvail", 32'(bus.o_tx_data_avail), 32'h1);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    stepCycle();
    checkOutput("rr.ackOneCycle", 32'(bus.o_ack), 32'h0);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(4'b0100, 1'b0, 1'b1);
    stepCycle();
    checkOutput("rr.firstDone", 32'(bus.o_done), 32'h2);
    checkOutput("rr.noAckOnDone", 32'(bus.o_ack), 32'h0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    stepCycle();
    checkOutput("rr.secondAck",  32'(bus.o_ack),          32'h4);
    checkOutput("rr.secondByte", 32'(bus.o_tx_data_byte), 32'h22);
    // Active and done together in WAIT_ACTIVE complete immediately.
    applyStimulus(4'b0000, 1'b1, 1'b1);
    stepCycle();
    checkOutput("rr.secondDone", 32'(bus.o_done), 32'h4);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    stepCycle();
    checkOutput("rr.idleAfter", 32'(bus.o_busy), 32'h0);

    // All four requesting, from a fresh reset: 0,1,2,3,0.
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      stepCycle();
`ifdef UART_ARB_PRIO0_EN
      expAck = 4'b0001;
`else
      expAck = 4'b0001 << (g % 4);
`endif
      checkOutput($sformatf("cycle.grant%0d", g), 32'(bus.o_ack), 32'(expAck));
      applyStimulus(4'b1111, 1'b0, 1'b1);
      stepCycle();
      checkOutput($sformatf("cycle.done%0d", g), 32'(bus.o_done), 32'(expAck));
      applyStimulus((g == 4) ? 4'b0000 : 4'b1111, 1'b0, 1'b0);
    end

    // Transmitter never starts: timeout after TO-1 cycles, no done.
    applyStimulus(4'b1010, 1'b0, 1'b0);
    stepCycle();
    checkOutput("to.ack", 32'(bus.o_ack), 32'h2);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    n = 0;
    sawDone = 0;
    while (!bus.o_timeout && n < 40) begin
      stepCycle();
      n++;
      if (bus.o_done != 4'b0000) sawDone = 1;
    end
    checkOutput("to.latency", 32'(n),        32'(TO - 1));
    checkOutput("to.noDone",  32'(sawDone),  32'h0);
    checkOutput("to.idle",    32'(bus.o_busy), 32'h0);
    stepCycle();
    checkOutput("to.pulseOnce", 32'(bus.o_timeout), 32'h0);
    applyStimulus(4'b1010, 1'b0, 1'b0);
    stepCycle();
    checkOutput("to.nextAck",  32'(bus.o_ack),          32'h8);
    checkOutput("to.nextByte", 32'(bus.o_tx_data_byte), 32'h44);

    // Request raised while busy waits until after the current done.
    applyStimulus(4'b0001, 1'b0, 1'b0);
    stepCycle();
    checkOutput("pend.noAck", 32'(bus.o_ack), 32'h0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(4'b0001, 1'b0, 1'b1);
    stepCycle();
    checkOutput("pend.done",       32'(bus.o_done), 32'h8);
    checkOutput("pend.noAckAtDone", 32'(bus.o_ack), 32'h0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    stepCycle();
    checkOutput("pend.ack",  32'(bus.o_ack),          32'h1);
    checkOutput("pend.byte", 32'(bus.o_tx_data_byte), 32'h55);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    stepCycle();
    checkOutput("pend.done0", 32'(bus.o_done), 32'h1);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    stepCycle();

    // Reset mid-transmission, then no grant while transmitter stays active.
    applyStimulus(4'b0010, 1'b0, 1'b0);
    stepCycle();
    checkOutput("rst.ack", 32'(bus.o_ack), 32'h2);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    repeat (4) stepCycle();
    rst = 1'b1;
    #1;
    checkOutput("rst.ackZero",     32'(bus.o_ack),           32'h0);
    checkOutput("rst.doneZero",    32'(bus.o_done),          32'h0);
    checkOutput("rst.timeoutZero", 32'(bus.o_timeout),       32'h0);
    checkOutput("rst.availZero",   32'(bus.o_tx_data_avail), 32'h0);
    checkOutput("rst.byteZero",    32'(bus.o_tx_data_byte),  32'h0);
    checkOutput("rst.ownerZero",   32'(bus.o_owner),         32'h0);
    checkOutput("rst.busyZero",    32'(bus.o_busy),          32'h0);
    repeat (2) stepCycle();
    rst = 1'b0;
    applyStimulus(4'b0001, 1'b1, 1'b0);
    for (int w = 0; w < 3; w++) begin
      stepCycle();
      checkOutput($sformatf("rst.blocked%0d", w), 32'(bus.o_ack), 32'h0);
    end
    applyStimulus(4'b0001, 1'b0, 1'b0);
    stepCycle();
    checkOutput("rst.grantAfter", 32'(bus.o_ack), 32'h1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    stepCycle();
    checkOutput("rst.finalDone", 32'(bus.o_done), 32'h1);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    repeat (2) stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter START_TIMEOUT, default 16, is the number of cycles to wait for the transmitter to report active or done after launch; legal range 2..255.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_req  input  4  per-requester transmit request; bit k belongs to requester k.
REQ-006 i_data  input  32  per-requester byte; requester k drives bits [8k+7:8k].
REQ-007 o_ack  output  4  one-cycle pulse on bit k when requester k's byte is latched.
REQ-008 o_done  output  4  one-cycle pulse on bit k when requester k's byte has finished transmitting.
REQ-009 o_timeout  output  1  one-cycle pulse when a launched byte is abandoned.
REQ-010 o_tx_data_avail  output  1  one-cycle launch strobe to the transmitter.
REQ-011 o_tx_data_byte  output  8  byte presented to the transmitter, held stable from launch until the state returns to IDLE.
REQ-012 i_tx_active  input  1  transmitter busy status.
REQ-013 i_tx_done  input  1  transmitter one-cycle completion pulse.
REQ-014 o_busy  output  1  high in any state other than IDLE.
REQ-015 o_owner  output  2  index of the current or most recent grantee.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_ACTIVE and WAIT_DONE.
REQ-017 IDLE: at an edge where any i_req bit is high and i_tx_active is low, the arbiter SHALL select one requester; otherwise it stays in IDLE.
REQ-018 At the same edge it SHALL do all of the following:
- register o_ack[sel]=1, o_tx_data_avail=1 and o_tx_data_byte=i_data[sel];
- register o_owner=sel;
- clear the timeout counter;
- go to WAIT_ACTIVE.
- Latency from the request edge to ack/strobe is 1 cycle.
REQ-019 o_ack and o_tx_data_avail SHALL be high for exactly one cycle per grant and SHALL never be high outside that cycle.
REQ-020 Round-robin order:
- search starts at (last_owner+1) mod 4 and ascends with wrap-around;
- last_owner resets to 3, so requester 0 has first priority after reset.
REQ-021 WAIT_ACTIVE:
- i_tx_done=1 -> finish (REQ-023); this takes precedence even if i_tx_active=1 in the same cycle;
- else i_tx_active=1 -> WAIT_DONE;
- else increment the counter; when it reaches START_TIMEOUT-1 -> pulse o_timeout, no o_done, go to IDLE.
REQ-022 WAIT_DONE: wait indefinitely for i_tx_done=1, then finish.
REQ-023 Finish SHALL pulse o_done[o_owner] for one cycle, update last_owner=o_owner and go to IDLE; a timeout SHALL also update last_owner.
REQ-024 A new grant SHALL NOT occur in the same cycle as o_done or o_timeout; the minimum gap between launches is 1 IDLE cycle.
REQ-025 i_req and i_data are sampled only in IDLE.
- Requests raised while busy stay pending.
- A request withdrawn before grant has no effect.
- Requesters drop i_req after o_ack; a request still high after o_ack is treated as a new byte.
REQ-026 o_tx_data_byte and o_owner SHALL hold their values in IDLE.

Reset
REQ-027 Asserting rst SHALL immediately, without waiting for a clock edge, set: state=IDLE, o_ack=0, o_done=0, o_timeout=0, o_tx_data_avail=0, o_tx_data_byte=0x00, o_owner=0, o_busy=0, last_owner=3, counter=0.
REQ-028 Reset mid-transmission SHALL abandon the byte with no o_done and no o_timeout; after release, IDLE waits for i_tx_active low before granting.

Configuration
REQ-029 Macro UART_ARB_PRIO0_EN: when defined, requester 0 SHALL win whenever i_req[0] is high, and round-robin applies among requesters 1..3 only when i_req[0] is low.
REQ-030 When UART_ARB_PRIO0_EN is not defined, pure round-robin per REQ-020 SHALL apply.

Verification
REQ-031 Reset, then i_req=4'b0110 with bytes 0x11/0x22 on requesters 1/2 -> req1 is acked first with o_tx_data_byte=0x11; after i_tx_done, req2 is granted with 0x22 -> o_done order is 1 then 2.
REQ-032 i_req=4'b1111 held and each byte completed -> grants cycle 0,1,2,3,0; under UART_ARB_PRIO0_EN -> grants are 0,0,0 while i_req[0] is held.
REQ-033 Launch with i_tx_active held low for 16 cycles -> o_timeout pulses 1 cycle; o_done stays 0; state returns to IDLE; the next grant goes to the next requester.
REQ-034 In WAIT_ACTIVE, i_tx_active=1 and i_tx_done=1 in the same cycle -> o_done[owner] pulses; state never enters WAIT_DONE.
REQ-035 rst asserted 3 cycles after i_tx_active rises -> all outputs are 0 that cycle; no o_done; with i_tx_active high and i_req=4'b0001, no grant occurs until i_tx_active falls.
REQ-036 i_req=4'b0001 raised while o_busy=1 -> no o_ack until 1 cycle after the current o_done.
